// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (IF) and load/store (DM); one read in flight.
// Optional MEM_ARB_RR_EN selects round-robin arbitration instead of fixed DM priority.
module mem_arbiter #(
    parameter int LAT   = 2,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_gnt_o,
    output logic        dm_rvalid_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        hold_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic done;
    logic eligible;
    logic dm_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_comb begin
        dm_win = dm_req_i && (!if_req_i || (last_q == OWN_IF));
    end
`else
    // last is kept so both builds share one register set; only round-robin reads it.
    logic unused_last;
    assign unused_last = last_q;

    always_comb begin
        dm_win = dm_req_i;
    end
`endif

    always_comb begin
        done     = (state_q == BUSY) && (cnt_q == CNT_W'(LAT - 1));
        eligible = (state_q == IDLE) || done;

        if_gnt_o    = eligible && if_req_i && !dm_win;
        dm_gnt_o    = eligible && dm_win;
        mem_req_o   = if_gnt_o || dm_gnt_o;
        mem_we_o    = dm_gnt_o && dm_we_i;
        mem_addr_o  = dm_gnt_o ? dm_addr_i : (if_gnt_o ? if_addr_i : 32'h0);
        mem_wdata_o = dm_gnt_o ? dm_wdata_i : 32'h0;

        if_rvalid_o = done && (owner_q == OWN_IF);
        dm_rvalid_o = done && (owner_q == OWN_DM);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
        dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : 32'h0;

        hold_o = (dm_req_i && !dm_gnt_o) ||
                 ((state_q == BUSY) && (owner_q == OWN_DM) && !dm_rvalid_o);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        if (state_q == BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (done) begin
            state_d = IDLE;
        end

        // A grant in the completion cycle overrides the return to IDLE for back-to-back reads.
        if (mem_req_o) begin
            last_d = dm_gnt_o;
            if (mem_we_o) begin
                state_d = IDLE;
            end else begin
                state_d = BUSY;
                owner_d = dm_gnt_o;
                cnt_d   = '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter: a LAT=2 instance driven from a cycle table,
// plus hand sequences for continuous contention and a LAT=1 instance.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic        if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o, hold_o;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

    logic        if_req1, dm_req1, dm_we1;
    logic [31:0] if_addr1, dm_addr1, dm_wdata1, mem_rdata1;
    logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_req1, mem_we1, hold1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LAT(2), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .hold_o(hold_o)
    );

    mem_arbiter #(.LAT(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_gnt_o(if_gnt1),
        .if_rvalid_o(if_rvalid1), .if_rdata_o(if_rdata1),
        .dm_req_i(dm_req1), .dm_we_i(dm_we1), .dm_addr_i(dm_addr1), .dm_wdata_i(dm_wdata1),
        .dm_gnt_o(dm_gnt1), .dm_rvalid_o(dm_rvalid1), .dm_rdata_o(dm_rdata1),
        .mem_req_o(mem_req1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
        .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1), .hold_o(hold1)
    );

    // ctl = {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, hold}
    typedef struct {
        logic        rst;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [31:0] mem_rdata;
        logic [6:0]  ctl;
        logic [31:0] if_rdata;
        logic [31:0] dm_rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw, input logic [31:0] da,
                                input logic [31:0] dd, input logic [31:0] mr,
                                input logic [6:0] c, input logic [31:0] ird,
                                input logic [31:0] drd, input logic [31:0] a,
                                input logic [31:0] w);
        vec_t v;
        v.rst = r; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
        v.dm_addr = da; v.dm_wdata = dd; v.mem_rdata = mr; v.ctl = c;
        v.if_rdata = ird; v.dm_rdata = drd; v.addr = a; v.wdata = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int          ng;
        logic [3:0]  won;
        logic [3:0]  exp_order;

        rst = 1'b1;
        if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = 0; dm_wdata_i = 0; mem_rdata_i = 0;
        if_req1 = 0; if_addr1 = 0; dm_req1 = 0; dm_we1 = 0;
        dm_addr1 = 0; dm_wdata1 = 0; mem_rdata1 = 0;

        //                r  ir ia     dr dw da     dd            mr             ctl         ird           drd           addr   wdata
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            0,             7'b0000000, 0,            0,            0,     0));
        vq.push_back(mk(0, 0, 0,     1, 1, 'h10,  'hDEADBEEF,   0,             7'b0010110, 0,            0,            'h10,  'hDEADBEEF));
        vq.push_back(mk(0, 1, 'h4,   0, 0, 0,     0,            0,             7'b1000100, 0,            0,            'h4,   0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            'h12345678,    7'b0000000, 0,            0,            0,     0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            'h00500093,    7'b0100000, 'h00500093,   0,            0,     0));
        vq.push_back(mk(0, 1, 'h8,   1, 0, 'h20,  0,            0,             7'b0010100, 0,            0,            'h20,  0));
        vq.push_back(mk(0, 1, 'h8,   0, 0, 0,     0,            0,             7'b0000001, 0,            0,            0,     0));
        vq.push_back(mk(0, 1, 'h8,   0, 0, 0,     0,            'hCAFEF00D,    7'b1001100, 0,            'hCAFEF00D,   'h8,   0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            0,             7'b0000000, 0,            0,            0,     0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            'h0BADC0DE,    7'b0100000, 'h0BADC0DE,   0,            0,     0));
        vq.push_back(mk(0, 0, 0,     1, 0, 'h30,  0,            0,             7'b0010100, 0,            0,            'h30,  0));
        vq.push_back(mk(1, 0, 0,     0, 0, 0,     0,            0,             7'b0000001, 0,            0,            0,     0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            'h11111111,    7'b0000000, 0,            0,            0,     0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            'h22222222,    7'b0000000, 0,            0,            0,     0));
        vq.push_back(mk(0, 1, 'hC,   1, 1, 'h40,  'h55,         0,             7'b0010110, 0,            0,            'h40,  'h55));
        vq.push_back(mk(0, 1, 'hC,   0, 0, 0,     0,            0,             7'b1000100, 0,            0,            'hC,   0));
        vq.push_back(mk(0, 0, 0,     1, 0, 'h50,  0,            0,             7'b0000001, 0,            0,            0,     0));
        vq.push_back(mk(0, 0, 0,     1, 0, 'h50,  0,            'h77,          7'b0110100, 'h77,         0,            'h50,  0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            0,             7'b0000001, 0,            0,            0,     0));
        vq.push_back(mk(0, 0, 0,     0, 0, 0,     0,            'h99,          7'b0001000, 0,            'h99,         0,     0));

        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            rst = vq[i].rst;
            if_req_i = vq[i].if_req;     if_addr_i = vq[i].if_addr;
            dm_req_i = vq[i].dm_req;     dm_we_i = vq[i].dm_we;
            dm_addr_i = vq[i].dm_addr;   dm_wdata_i = vq[i].dm_wdata;
            mem_rdata_i = vq[i].mem_rdata;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o, mem_req_o, mem_we_o, hold_o,
                 if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o},
                {vq[i].ctl, vq[i].if_rdata, vq[i].dm_rdata, vq[i].addr, vq[i].wdata});
        end

        // Continuous contention after reset: both requesters read on every eligible cycle.
        @(posedge clk); #1;
        rst = 1'b1; if_req_i = 0; dm_req_i = 0; dm_we_i = 0; mem_rdata_i = 0;
        @(posedge clk); #1;
        rst = 1'b0; if_req_i = 1; if_addr_i = 'h100; dm_req_i = 1; dm_addr_i = 'h200;
        ng = 0;
        won = '0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            @(negedge clk);
            if (if_gnt_o || dm_gnt_o) begin
                won[ng] = dm_gnt_o;
                ng++;
            end
            @(posedge clk); #1;
        end
        if_req_i = 0; dm_req_i = 0;
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        chk("contention_grant_count", 135'(ng), 135'(4));
        chk("contention_grant_order", 135'(won), 135'(exp_order));

        // LAT=1 instance: back-to-back DM loads.
        dm_req1 = 1; dm_we1 = 0; dm_addr1 = 'h0; mem_rdata1 = 0;
        @(negedge clk);
        chk("lat1_c0_ctl", 135'({dm_gnt1, dm_rvalid1, mem_req1, hold1}), 135'(4'b1010));
        chk("lat1_c0_addr", 135'(mem_addr1), 135'(32'h0));
        @(posedge clk); #1;
        dm_addr1 = 'h4; mem_rdata1 = 'hA0;
        @(negedge clk);
        chk("lat1_c1_ctl", 135'({dm_gnt1, dm_rvalid1, mem_req1, hold1}), 135'(4'b1110));
        chk("lat1_c1_data", 135'({mem_addr1, dm_rdata1}), 135'({32'h4, 32'hA0}));
        @(posedge clk); #1;
        dm_req1 = 0; mem_rdata1 = 'hA4;
        @(negedge clk);
        chk("lat1_c2_ctl", 135'({dm_gnt1, dm_rvalid1, mem_req1, hold1}), 135'(4'b0100));
        chk("lat1_c2_data", 135'(dm_rdata1), 135'(32'hA4));
        @(posedge clk); #1;
        mem_rdata1 = 'hFF;
        @(negedge clk);
        chk("lat1_c3_idle", 135'({dm_gnt1, dm_rvalid1, mem_req1, hold1, dm_rdata1}), 135'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
